ex_stage: RTL and testbench

//  Execute stage of the 5-stage MIPS pipeline. Consumes the ID_EX register outputs.

---
 rtl/ex_stage.sv | 243 ++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: single-cycle ALU, iterative mul/div into HI/LO,
// and the EX/MEM output latch. o_stall freezes upstream while a mul/div is in flight.
module ex_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic [DATA_WIDTH-1:0] i_data1,
    input  logic [DATA_WIDTH-1:0] i_data2,
    input  logic [DATA_WIDTH-1:0] i_imme,
    input  logic [4:0]            i_rd,
    input  logic [4:0]            i_rt,
    input  logic [5:0]            i_EX,
    input  logic [2:0]            i_M,
    input  logic [1:0]            i_WB,
    output logic                  o_stall,
    output logic [DATA_WIDTH-1:0] o_alu_result,
    output logic [DATA_WIDTH-1:0] o_store_data,
    output logic [4:0]            o_dst,
    output logic                  o_zero,
    output logic [DATA_WIDTH-1:0] o_branch_target,
    output logic [2:0]            o_M,
    output logic [1:0]            o_WB,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DW + 1);

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_AND    = 4'd2;
    localparam logic [3:0] OP_OR     = 4'd3;
    localparam logic [3:0] OP_XOR    = 4'd4;
    localparam logic [3:0] OP_NOR    = 4'd5;
    localparam logic [3:0] OP_SLT    = 4'd6;
    localparam logic [3:0] OP_SLTU   = 4'd7;
    localparam logic [3:0] OP_SLL    = 4'd8;
    localparam logic [3:0] OP_SRL    = 4'd9;
    localparam logic [3:0] OP_SRA    = 4'd10;
    localparam logic [3:0] OP_MULT   = 4'd11;
    localparam logic [3:0] OP_MULTU  = 4'd12;
    localparam logic [3:0] OP_DIV    = 4'd13;
    localparam logic [3:0] OP_DIVU   = 4'd14;
    localparam logic [3:0] OP_MFHILO = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          is_div_q;
    logic          neg_a_q;
    logic          neg_b_q;
    logic [DW-1:0] b_q;
    logic [DW-1:0] acc_hi_q;
    logic [DW-1:0] acc_lo_q;
    logic [DW-1:0] hi_q;
    logic [DW-1:0] lo_q;

    logic [DW-1:0] alu_result_q, store_data_q, branch_target_q;
    logic [4:0]    dst_q;
    logic          zero_q;
    logic [2:0]    m_q;
    logic [1:0]    wb_q;

    logic [DW-1:0] alu_result_d, store_data_d, branch_target_d;
    logic [4:0]    dst_d;
    logic          zero_d;
    logic [2:0]    m_d;
    logic [1:0]    wb_d;

    logic [3:0]    alu_op;
    logic [DW-1:0] op_b;
    logic [4:0]    shamt;
    logic          is_md;
    logic          is_signed_md;
    logic          is_div_op;

    assign alu_op       = i_EX[3:0];
    assign op_b         = i_EX[4] ? i_imme : i_data2;
    assign shamt        = i_imme[10:6];
    assign is_md        = (alu_op >= OP_MULT) && (alu_op <= OP_DIVU);
    assign is_signed_md = (alu_op == OP_MULT) || (alu_op == OP_DIV);
    assign is_div_op    = (alu_op == OP_DIV) || (alu_op == OP_DIVU);
    assign o_stall      = (state_q == BUSY) || ((state_q == IDLE) && is_md);

    logic [DW-1:0] alu_res;
    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:    alu_res = i_data1 + op_b;
            OP_SUB:    alu_res = i_data1 - op_b;
            OP_AND:    alu_res = i_data1 & op_b;
            OP_OR:     alu_res = i_data1 | op_b;
            OP_XOR:    alu_res = i_data1 ^ op_b;
            OP_NOR:    alu_res = ~(i_data1 | op_b);
            OP_SLT:    alu_res = {{(DW-1){1'b0}}, ($signed(i_data1) < $signed(op_b))};
            OP_SLTU:   alu_res = {{(DW-1){1'b0}}, (i_data1 < op_b)};
            OP_SLL:    alu_res = i_data2 << shamt;
            OP_SRL:    alu_res = i_data2 >> shamt;
            OP_SRA:    alu_res = $signed(i_data2) >>> shamt;
            OP_MFHILO: alu_res = i_imme[0] ? hi_q : lo_q;
            default:   alu_res = '0;
        endcase
    end

    // The iteration works on magnitudes; signs are re-applied when HI/LO are written.
    logic          neg_a, neg_b;
    logic [DW-1:0] abs_a, abs_b;
    assign neg_a = is_signed_md & i_data1[DW-1];
    assign neg_b = is_signed_md & op_b[DW-1];
    assign abs_a = neg_a ? -i_data1 : i_data1;
    assign abs_b = neg_b ? -op_b : op_b;

    logic [DW:0]   mul_sum, div_shift, div_diff;
    logic          div_ge;
    logic [DW-1:0] step_hi_d, step_lo_d;
    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : {(DW+1){1'b0}});
    assign div_shift = {acc_hi_q, acc_lo_q[DW-1]};
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_ge    = div_shift >= {1'b0, b_q};

    always_comb begin
        if (is_div_q) begin
            step_hi_d = div_ge ? div_diff[DW-1:0] : div_shift[DW-1:0];
            step_lo_d = {acc_lo_q[DW-2:0], div_ge};
        end else begin
            step_hi_d = mul_sum[DW:1];
            step_lo_d = {mul_sum[0], acc_lo_q[DW-1:1]};
        end
    end

    // Dividing by zero leaves rem = |dividend|, so only the quotient needs overriding.
    logic [2*DW-1:0] prod;
    logic [DW-1:0]   fix_hi_d, fix_lo_d;
    always_comb begin
        prod     = {acc_hi_q, acc_lo_q};
        fix_hi_d = acc_hi_q;
        fix_lo_d = acc_lo_q;
        if (is_div_q) begin
            fix_hi_d = neg_a_q ? -acc_hi_q : acc_hi_q;
            if (b_q == '0) begin
                fix_lo_d = '1;
            end else if (neg_a_q ^ neg_b_q) begin
                fix_lo_d = -acc_lo_q;
            end
        end else if (neg_a_q ^ neg_b_q) begin
            {fix_hi_d, fix_lo_d} = -prod;
        end
    end

    always_comb begin
        alu_result_d    = '0;
        store_data_d    = '0;
        dst_d           = '0;
        zero_d          = 1'b0;
        branch_target_d = '0;
        m_d             = '0;
        wb_d            = '0;
        if (!o_stall) begin
            alu_result_d    = is_md ? '0 : alu_res;
            store_data_d    = i_data2;
            dst_d           = i_EX[5] ? i_rd : i_rt;
            zero_d          = (alu_result_d == '0);
            branch_target_d = i_pc + (i_imme << 2);
            m_d             = i_M;
            wb_d            = i_WB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            is_div_q        <= 1'b0;
            neg_a_q         <= 1'b0;
            neg_b_q         <= 1'b0;
            b_q             <= '0;
            acc_hi_q        <= '0;
            acc_lo_q        <= '0;
            hi_q            <= '0;
            lo_q            <= '0;
            alu_result_q    <= '0;
            store_data_q    <= '0;
            dst_q           <= '0;
            zero_q          <= 1'b0;
            branch_target_q <= '0;
            m_q             <= '0;
            wb_q            <= '0;
        end else begin
            alu_result_q    <= alu_result_d;
            store_data_q    <= store_data_d;
            dst_q           <= dst_d;
            zero_q          <= zero_d;
            branch_target_q <= branch_target_d;
            m_q             <= m_d;
            wb_q            <= wb_d;
            case (state_q)
                IDLE: begin
                    if (is_md) begin
                        is_div_q <= is_div_op;
                        neg_a_q  <= neg_a;
                        neg_b_q  <= neg_b;
                        b_q      <= abs_b;
                        acc_hi_q <= '0;
                        acc_lo_q <= abs_a;
                        cnt_q    <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    acc_hi_q <= step_hi_d;
                    acc_lo_q <= step_lo_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CW'(DW - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    hi_q    <= fix_hi_d;
                    lo_q    <= fix_lo_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_alu_result    = alu_result_q;
    assign o_store_data    = store_data_q;
    assign o_dst           = dst_q;
    assign o_zero          = zero_q;
    assign o_branch_target = branch_target_q;
    assign o_M             = m_q;
    assign o_WB            = wb_q;
    assign o_hi            = hi_q;
    assign o_lo            = lo_q;
endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - randomized self-checking bench for ex_stage against an arithmetic model.
module tb_ex_stage;
    localparam int DW = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imme;
        logic [4:0]  rd;
        logic [4:0]  rt;
        logic [5:0]  ex;
        logic [2:0]  m;
        logic [1:0]  wb;
    } instr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_pc, i_data1, i_data2, i_imme;
    logic [4:0]  i_rd, i_rt;
    logic [5:0]  i_EX;
    logic [2:0]  i_M;
    logic [1:0]  i_WB;
    logic        o_stall, o_zero;
    logic [31:0] o_alu_result, o_store_data, o_branch_target, o_hi, o_lo;
    logic [4:0]  o_dst;
    logic [2:0]  o_M;
    logic [1:0]  o_WB;

    always #5 clk = ~clk;

    ex_stage #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .i_pc(i_pc), .i_data1(i_data1), .i_data2(i_data2),
        .i_imme(i_imme), .i_rd(i_rd), .i_rt(i_rt), .i_EX(i_EX), .i_M(i_M), .i_WB(i_WB),
        .o_stall(o_stall), .o_alu_result(o_alu_result), .o_store_data(o_store_data),
        .o_dst(o_dst), .o_zero(o_zero), .o_branch_target(o_branch_target),
        .o_M(o_M), .o_WB(o_WB), .o_hi(o_hi), .o_lo(o_lo)
    );

    int tests = 0;
    int fails = 0;
    int stall_seen;

    logic [31:0] m_hi = '0, m_lo = '0;
    int          m_md = 0;
    logic [31:0] e_alu, e_store, e_tgt;
    logic [4:0]  e_dst;
    logic        e_zero, e_stall;
    logic [2:0]  e_M;
    logic [1:0]  e_WB;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] d2,
                                            input logic [31:0] imme);
        int sa, sb, sd, sh;
        sa = a; sb = b; sd = d2; sh = int'(imme[10:6]);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return d2 << sh;
            4'd9:  return d2 >> sh;
            4'd10: return sd >>> sh;
            4'd15: return imme[0] ? m_hi : m_lo;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic is_md_op(input logic [3:0] op);
        return (op >= 4'd11) && (op <= 4'd14);
    endfunction

    task automatic md_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint            la, lb;
        longint unsigned   ua, ub, p;
        int                ia, ib;
        ia = a; ib = b; la = ia; lb = ib; ua = a; ub = b;
        case (op)
            4'd11: begin p = la * lb; m_hi = p[63:32]; m_lo = p[31:0]; end
            4'd12: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
            4'd13: begin
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = a; m_hi = 0; end
                else begin m_lo = ia / ib; m_hi = ia % ib; end
            end
            default: begin
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else begin m_lo = a / b; m_hi = a % b; end
            end
        endcase
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        logic [3:0]  op;
        logic [31:0] b, res;
        if (rst) begin
            e_alu = 0; e_store = 0; e_tgt = 0; e_dst = 0; e_zero = 0; e_M = 0; e_WB = 0;
            m_hi = 0; m_lo = 0; m_md = 0;
            return;
        end
        op = i_EX[3:0];
        if (is_md_op(op) && m_md < DW + 1) begin
            e_alu = 0; e_store = 0; e_tgt = 0; e_dst = 0; e_zero = 0; e_M = 0; e_WB = 0;
            m_md++;
            return;
        end
        b   = i_EX[4] ? i_imme : i_data2;
        res = ref_alu(op, i_data1, b, i_data2, i_imme);
        if (is_md_op(op)) begin
            md_result(op, i_data1, b);
            m_md = 0;
            res  = 0;
        end
        e_alu = res; e_store = i_data2; e_dst = i_EX[5] ? i_rd : i_rt;
        e_zero = (res == 0); e_tgt = i_pc + (i_imme << 2); e_M = i_M; e_WB = i_WB;
    endtask

    task automatic drive(input instr_t x, input logic r);
        rst = r; i_pc = x.pc; i_data1 = x.d1; i_data2 = x.d2; i_imme = x.imme;
        i_rd = x.rd; i_rt = x.rt; i_EX = x.ex; i_M = x.m; i_WB = x.wb;
    endtask

    task automatic compare();
        chk("stall", 32'(o_stall), 32'(e_stall));
        chk("alu_result", o_alu_result, e_alu);
        chk("store_data", o_store_data, e_store);
        chk("dst", 32'(o_dst), 32'(e_dst));
        chk("zero", 32'(o_zero), 32'(e_zero));
        chk("branch_target", o_branch_target, e_tgt);
        chk("M", 32'(o_M), 32'(e_M));
        chk("WB", 32'(o_WB), 32'(e_WB));
        chk("hi", o_hi, m_hi);
        chk("lo", o_lo, m_lo);
    endtask

    task automatic tick(input instr_t x, input logic r);
        @(posedge clk);
        #1;
        model_edge();
        drive(x, r);
        e_stall = is_md_op(x.ex[3:0]) && (m_md < DW + 1);
        @(negedge clk);
        compare();
    endtask

    task automatic issue(input instr_t x);
        int guard;
        guard = 0;
        stall_seen = 0;
        tick(x, 1'b0);
        if (o_stall) stall_seen++;
        while (e_stall && guard < 100) begin
            tick(x, 1'b0);
            if (o_stall) stall_seen++;
            guard++;
        end
        if (guard >= 100) begin
            fails++;
            $display("FAIL issue_timeout: got stall after %0d cycles expected release", guard);
        end
    endtask

    function automatic instr_t mk(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                                  input logic [31:0] imme, input logic regdst, input logic alusrc,
                                  input logic [4:0] rd, input logic [4:0] rt, input logic [2:0] m,
                                  input logic [1:0] wb, input logic [31:0] pc);
        instr_t x;
        x.pc = pc; x.d1 = d1; x.d2 = d2; x.imme = imme; x.rd = rd; x.rt = rt;
        x.ex = {regdst, alusrc, op}; x.m = m; x.wb = wb;
        return x;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom % 8)
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t nop, x;
        logic [3:0] op;
        nop = '0;
        drive(nop, 1'b1);
        tick(nop, 1'b1);
        chk("reset_alu", o_alu_result, 32'h0);
        chk("reset_hi", o_hi, 32'h0);
        tick(nop, 1'b0);

        issue(mk(4'd0, 32'd5, 32'd7, 32'd0, 1'b1, 1'b0, 5'd3, 5'd9, 3'b000, 2'b10, 32'h40));
        tick(nop, 1'b0);
        chk("add_result", o_alu_result, 32'd12);
        chk("add_dst", 32'(o_dst), 32'd3);
        chk("add_zero", 32'(o_zero), 32'd0);

        issue(mk(4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 5'd4, 5'd0, 3'b000, 2'b10, 32'h44));
        issue(mk(4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 5'd5, 5'd0, 3'b000, 2'b10, 32'h48));
        chk("slt_result", o_alu_result, 32'd1);
        tick(nop, 1'b0);
        chk("sltu_result", o_alu_result, 32'd0);

        issue(mk(4'd11, 32'hFFFF_FFFD, 32'd5, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 3'b000, 2'b00, 32'h4C));
        chk("mult_stall_cycles", stall_seen, 32'd33);
        issue(mk(4'd15, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd8, 5'd0, 3'b000, 2'b10, 32'h50));
        chk("mult_hi", o_hi, 32'hFFFF_FFFF);
        chk("mult_lo", o_lo, 32'hFFFF_FFF1);
        tick(nop, 1'b0);
        chk("mfhilo_lo", o_alu_result, 32'hFFFF_FFF1);

        issue(mk(4'd13, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 3'b000, 2'b00, 32'h54));
        tick(nop, 1'b0);
        chk("div_lo", o_lo, 32'hFFFF_FFFD);
        chk("div_hi", o_hi, 32'hFFFF_FFFF);
        issue(mk(4'd14, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 3'b000, 2'b00, 32'h58));
        tick(nop, 1'b0);
        chk("divu0_lo", o_lo, 32'hFFFF_FFFF);
        chk("divu0_hi", o_hi, 32'h0000_0007);

        x = mk(4'd13, 32'd100, 32'd3, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 3'b000, 2'b00, 32'h5C);
        for (int i = 0; i < 11; i++) tick(x, 1'b0);
        tick(x, 1'b1);
        tick(nop, 1'b0);
        chk("rst_mid_div_stall", 32'(o_stall), 32'd0);
        chk("rst_mid_div_hi", o_hi, 32'h0);
        chk("rst_mid_div_lo", o_lo, 32'h0);
        chk("rst_mid_div_alu", o_alu_result, 32'h0);

        issue(mk(4'd1, 32'd9, 32'd9, 32'd4, 1'b0, 1'b0, 5'd0, 5'd0, 3'b100, 2'b00, 32'h100));
        tick(nop, 1'b0);
        chk("beq_zero", 32'(o_zero), 32'd1);
        chk("beq_target", o_branch_target, 32'h110);
        chk("beq_branch", 32'(o_M[2]), 32'd1);

        for (int n = 0; n < 400; n++) begin
            op = 4'($urandom % 16);
            if (is_md_op(op) && ($urandom % 3 != 0)) op = 4'($urandom % 11);
            x = mk(op, rnd_val(), rnd_val(), $urandom, 1'($urandom), 1'($urandom % 4 == 0),
                   5'($urandom), 5'($urandom), 3'($urandom), 2'($urandom), $urandom);
            if ($urandom % 50 == 0) tick(x, 1'b1);
            else issue(x);
        end
        tick(nop, 1'b0);
        tick(nop, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
